// File: rtl/ring_fifo.sv
// Circular-buffer FIFO with registered output, occupancy count and status flags.
// Define RING_FIFO_ERR_FLAGS_EN to enable sticky overflow/underflow reporting.
module ring_fifo #(
  parameter int DATA_WIDTH         = 32,
  parameter int FIFO_DEPTH         = 16,
  parameter int ALMOST_FULL_LEVEL  = 14,
  parameter int ALMOST_EMPTY_LEVEL = 2
) (
  input  logic                          clk,
  input  logic                          clear,
  input  logic                          enable,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_valid,
  output logic [$clog2(FIFO_DEPTH):0]   data_count,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  vld_q, vld_d;
  logic                  push_ok, pop_ok;

  // A pop frees a slot in the same cycle, so a push while full is accepted
  // alongside a pop; a pop while empty is never accepted.
  assign pop_ok  = enable & pop  & (count_q != '0);
  assign push_ok = enable & push & ((count_q != CW'(FIFO_DEPTH)) | pop_ok);

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    out_d   = out_q;
    vld_d   = 1'b0;
    if (push_ok) wr_d = wr_q + AW'(1);
    if (pop_ok) begin
      rd_d  = rd_q + AW'(1);
      out_d = mem_q[rd_q];
      vld_d = 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
    end
  end

  // Storage carries no reset; stale words are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= in_data;
  end

`ifdef RING_FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d, udf_q, udf_d;

  always_comb begin
    ovf_d = ovf_q | (enable & push & ~push_ok);
    udf_d = udf_q | (enable & pop  & ~pop_ok);
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign out_data     = out_q;
  assign out_valid    = vld_q;
  assign data_count   = count_q;
  assign full         = (count_q == CW'(FIFO_DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(ALMOST_FULL_LEVEL));
  assign almost_empty = (count_q <= CW'(ALMOST_EMPTY_LEVEL));

endmodule

// File: tb/tb_ring_fifo.sv
// Self-checking bench for ring_fifo: directed scenarios plus randomized traffic
// scored against a queue-based reference model.
module tb_ring_fifo;
  localparam int DW = 32;
  localparam int D  = 16;
  localparam int AF = 14;
  localparam int AE = 2;
`ifdef RING_FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          clear, enable, push, pop;
  logic [DW-1:0] in_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic [4:0]    data_count;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;

  ring_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(D), .ALMOST_FULL_LEVEL(AF),
              .ALMOST_EMPTY_LEVEL(AE)) dut (
    .clk(clk), .clear(clear), .enable(enable), .push(push), .pop(pop),
    .in_data(in_data), .out_data(out_data), .out_valid(out_valid),
    .data_count(data_count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_out;
  bit            m_vld, m_ovf, m_udf;

  function automatic void model_clear();
    q.delete();
    m_out = '0; m_vld = 0; m_ovf = 0; m_udf = 0;
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, return at negedge.
  task automatic step(input bit en, input bit pu, input bit po, input logic [DW-1:0] d);
    bit pop_acc, push_acc;
    enable = en; push = pu; pop = po; in_data = d;
    @(posedge clk);
    m_vld = 0;
    if (en) begin
      pop_acc  = po && q.size() > 0;
      push_acc = pu && (q.size() < D || pop_acc);
      if (pop_acc) begin m_out = q.pop_front(); m_vld = 1; end
      if (push_acc) q.push_back(d);
      if (ERR_EN && pu && !push_acc) m_ovf = 1;
      if (ERR_EN && po && !pop_acc)  m_udf = 1;
    end
    @(negedge clk);
    enable = 0; push = 0; pop = 0;
  endtask

  task automatic do_clear();
    clear = 1;
    #1;
    model_clear();
    @(negedge clk);
    clear = 0;
  endtask

  task automatic test_reset();
    clear = 1; enable = 0; push = 0; pop = 0; in_data = '0;
    #3;
    model_clear();
    n_checks++;
    if (data_count !== 5'd0 || empty !== 1 || almost_empty !== 1 || full !== 0 ||
        almost_full !== 0 || out_valid !== 0 || out_data !== '0 ||
        overflow !== 0 || underflow !== 0) begin
      n_fail++;
      $display("FAIL reset: cnt=%0d e=%b ae=%b f=%b af=%b v=%b d=%0h o=%b u=%b want cnt=0 e=1 ae=1 f=0 af=0 v=0 d=0 o=0 u=0",
               data_count, empty, almost_empty, full, almost_full, out_valid, out_data, overflow, underflow);
    end
    @(negedge clk);
    clear = 0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      step(1, 1, 0, DW'(32'h11 + i));
      n_checks++;
      if (almost_full !== (i + 1 >= AF) || full !== (i + 1 == D) ||
          data_count !== 5'(i + 1) || almost_empty !== (i + 1 <= AE) || empty !== 0) begin
        n_fail++;
        $display("FAIL fill[%0d]: cnt=%0d af=%b f=%b ae=%b e=%b want cnt=%0d af=%b f=%b ae=%b e=0",
                 i, data_count, almost_full, full, almost_empty, empty,
                 i + 1, i + 1 >= AF, i + 1 == D, i + 1 <= AE);
      end
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 1, '0);
      n_checks++;
      if (out_valid !== 1 || out_data !== DW'(32'h11 + i) || out_data !== m_out) begin
        n_fail++;
        $display("FAIL drain[%0d]: v=%b d=%0h want v=1 d=%0h", i, out_valid, out_data, 32'h11 + i);
      end
    end
    step(1, 0, 0, '0);
    n_checks++;
    if (out_valid !== 0 || empty !== 1 || data_count !== 5'd0 || out_data !== 32'h20) begin
      n_fail++;
      $display("FAIL drain_end: v=%b e=%b cnt=%0d d=%0h want v=0 e=1 cnt=0 d=20",
               out_valid, empty, data_count, out_data);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) step(1, 1, 0, DW'(32'h100 + i));
    step(1, 1, 0, 32'hDEAD);
    n_checks++;
    if (data_count !== 5'd16 || full !== 1 || overflow !== ERR_EN) begin
      n_fail++;
      $display("FAIL overflow: cnt=%0d f=%b ovf=%b want cnt=16 f=1 ovf=%b",
               data_count, full, overflow, ERR_EN);
    end
    // full + push + pop: oldest leaves, new word enters
    step(1, 1, 1, 32'hBEEF);
    n_checks++;
    if (out_data !== 32'h100 || out_valid !== 1 || data_count !== 5'd16) begin
      n_fail++;
      $display("FAIL full_pushpop: d=%0h v=%b cnt=%0d want d=100 v=1 cnt=16",
               out_data, out_valid, data_count);
    end
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 1, '0);
      n_checks++;
      if (out_data === 32'hDEAD || out_data !== m_out || out_valid !== 1) begin
        n_fail++;
        $display("FAIL ovf_drain[%0d]: d=%0h v=%b want d=%0h v=1", i, out_data, out_valid, m_out);
      end
    end
    n_checks++;
    if (m_out !== 32'hBEEF || empty !== 1) begin
      n_fail++;
      $display("FAIL ovf_last: last=%0h e=%b want last=beef e=1", m_out, empty);
    end
  endtask

  task automatic test_empty_pushpop();
    do_clear();
    step(1, 1, 1, 32'hA5);
    n_checks++;
    if (data_count !== 5'd1 || out_valid !== 0 || underflow !== ERR_EN || out_data !== '0) begin
      n_fail++;
      $display("FAIL empty_pushpop: cnt=%0d v=%b udf=%b d=%0h want cnt=1 v=0 udf=%b d=0",
               data_count, out_valid, underflow, out_data, ERR_EN);
    end
    step(1, 0, 1, '0);
    n_checks++;
    if (out_data !== 32'hA5 || out_valid !== 1 || empty !== 1 || underflow !== ERR_EN) begin
      n_fail++;
      $display("FAIL empty_next_pop: d=%0h v=%b e=%b udf=%b want d=a5 v=1 e=1 udf=%b",
               out_data, out_valid, empty, underflow, ERR_EN);
    end
  endtask

  task automatic test_back_to_back();
    do_clear();
    for (int i = 0; i < 8; i++) step(1, 1, 0, $urandom);
    for (int i = 0; i < 40; i++) begin
      step(1, 1, 1, $urandom);
      n_checks++;
      if (data_count !== 5'd8 || out_valid !== 1 || out_data !== m_out) begin
        n_fail++;
        $display("FAIL b2b[%0d]: cnt=%0d v=%b d=%0h want cnt=8 v=1 d=%0h",
                 i, data_count, out_valid, out_data, m_out);
      end
    end
  endtask

  task automatic test_enable_hold();
    logic [DW-1:0] d0;
    d0 = out_data;
    step(0, 1, 1, 32'h77);
    n_checks++;
    if (data_count !== 5'(q.size()) || out_valid !== 0 || out_data !== d0 ||
        overflow !== m_ovf || underflow !== m_udf) begin
      n_fail++;
      $display("FAIL enable_hold: cnt=%0d v=%b d=%0h want cnt=%0d v=0 d=%0h",
               data_count, out_valid, out_data, q.size(), d0);
    end
  endtask

  task automatic test_clear_mid();
    do_clear();
    for (int i = 0; i < 5; i++) step(1, 1, 0, DW'(i + 1));
    step(1, 0, 1, '0);
    step(1, 1, 0, 32'h55);
    enable = 1; push = 1; pop = 1; in_data = 32'h99;
    #2 clear = 1;
    #1;
    model_clear();
    n_checks++;
    if (data_count !== 5'd0 || empty !== 1 || almost_empty !== 1 || full !== 0 ||
        almost_full !== 0 || out_valid !== 0 || out_data !== '0 ||
        overflow !== 0 || underflow !== 0) begin
      n_fail++;
      $display("FAIL clear_mid: cnt=%0d e=%b v=%b d=%0h o=%b u=%b want all reset",
               data_count, empty, out_valid, out_data, overflow, underflow);
    end
    enable = 0; push = 0; pop = 0;
    @(negedge clk);
    clear = 0;
    step(0, 1, 0, 32'h33);
    n_checks++;
    if (data_count !== 5'd0 || empty !== 1) begin
      n_fail++;
      $display("FAIL clear_en0: cnt=%0d e=%b want cnt=0 e=1", data_count, empty);
    end
    step(1, 1, 0, 32'h44);
    n_checks++;
    if (data_count !== 5'd1) begin
      n_fail++;
      $display("FAIL clear_release: cnt=%0d want 1", data_count);
    end
  endtask

  task automatic test_random();
    do_clear();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom);
      n_checks++;
      if (data_count !== 5'(q.size()) || out_valid !== m_vld || out_data !== m_out ||
          full !== (q.size() == D) || empty !== (q.size() == 0) ||
          almost_full !== (q.size() >= AF) || almost_empty !== (q.size() <= AE) ||
          overflow !== m_ovf || underflow !== m_udf) begin
        n_fail++;
        $display("FAIL random[%0d]: cnt=%0d v=%b d=%0h o=%b u=%b want cnt=%0d v=%b d=%0h o=%b u=%b",
                 i, data_count, out_valid, out_data, overflow, underflow,
                 q.size(), m_vld, m_out, m_ovf, m_udf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_overflow();
    test_empty_pushpop();
    test_back_to_back();
    test_enable_hold();
    test_clear_mid();
    test_random();
    test_enable_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
